// File: rtl/fp_prep_pipe.sv
// Operand-preparation stage for the FP multiplier: unpacks two IEEE-754-style
// operands and presents them through a registered valid/ready stage with a 2-entry skid buffer.
module fp_prep_pipe #(
   parameter int EW          = 8,
   parameter int FW          = 23,
   parameter int DENORM_MODE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [EW+FW:0] a,
   input  logic [EW+FW:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           sa,
   output logic           sb,
   output logic           s_prod,
   output logic [EW-1:0]  ea,
   output logic [EW-1:0]  eb,
   output logic [FW:0]    ma,
   output logic [FW:0]    mb,
   output logic [6:0]     exc
);

   localparam logic KEEP_SUB = (DENORM_MODE != 0);

   typedef struct packed {
      logic          sgn;
      logic [EW-1:0] e;
      logic [FW:0]   m;
      logic          zero;
      logic          inf;
      logic          nan;
   } opnd_t;

   typedef struct packed {
      logic          sa;
      logic          sb;
      logic          s_prod;
      logic [EW-1:0] ea;
      logic [EW-1:0] eb;
      logic [FW:0]   ma;
      logic [FW:0]   mb;
      logic [6:0]    exc;
   } res_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Subnormals either flush to zero or keep an effective exponent of 1 with hidden bit 0.
   function automatic opnd_t decode(input logic [EW+FW:0] x);
      opnd_t         d;
      logic [EW-1:0] ex;
      logic [FW-1:0] fr;
      logic          ex_zero;
      logic          ex_ones;
      logic          fr_zero;
      ex      = x[EW+FW-1:FW];
      fr      = x[FW-1:0];
      ex_zero = (ex == {EW{1'b0}});
      ex_ones = (ex == {EW{1'b1}});
      fr_zero = (fr == {FW{1'b0}});
      d.sgn   = x[EW+FW];
      d.zero  = ex_zero & (fr_zero | ~KEEP_SUB);
      d.inf   = ex_ones & fr_zero;
      d.nan   = ex_ones & ~fr_zero;
      if (d.zero) begin
         d.e = {EW{1'b0}};
         d.m = {(FW+1){1'b0}};
      end else if (ex_zero) begin
         d.e = {{(EW-1){1'b0}}, 1'b1};
         d.m = {1'b0, fr};
      end else begin
         d.e = ex;
         d.m = {1'b1, fr};
      end
      return d;
   endfunction

   opnd_t  da;
   opnd_t  db;
   res_t   dec;
   res_t   m_data;
   res_t   s_data;
   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   emit;
   logic   load_m;
   logic   load_s;
   logic   m_from_s;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   // Combinational decode of the offered pair, captured only on accept.
   always_comb begin
      da         = decode(a);
      db         = decode(b);
      dec.sa     = da.sgn;
      dec.sb     = db.sgn;
      dec.s_prod = da.sgn ^ db.sgn;
      dec.ea     = da.e;
      dec.eb     = db.e;
      dec.ma     = da.m;
      dec.mb     = db.m;
      dec.exc    = {da.nan | db.nan | (da.inf & db.zero) | (da.zero & db.inf),
                    da.nan, db.nan, da.inf, db.inf, da.zero, db.zero};
   end

   // Occupancy state plus registered handshake flags derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != FULL);
         out_valid <= (state_nxt != EMPTY);
      end
   end

   // Next occupancy from accept/emit events.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (accept) state_nxt = ONE;
            else        state_nxt = EMPTY;
         end
         ONE: begin
            if (accept & ~emit)      state_nxt = FULL;
            else if (emit & ~accept) state_nxt = EMPTY;
            else                     state_nxt = ONE;
         end
         FULL: begin
            if (emit) state_nxt = ONE;
            else      state_nxt = FULL;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Register load controls; in FULL the skid entry refills the output register on emit.
   always_comb begin
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
      case (state)
         EMPTY: load_m = accept;
         ONE: begin
            load_m = accept & emit;
            load_s = accept & ~emit;
         end
         FULL: begin
            load_m   = emit;
            m_from_s = 1'b1;
         end
         default: begin
            load_m   = 1'b0;
            load_s   = 1'b0;
            m_from_s = 1'b0;
         end
      endcase
   end

   // Main output register M and skid register S; M holds while not reloaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data <= '0;
         s_data <= '0;
      end else begin
         if (load_m) m_data <= m_from_s ? s_data : dec;
         if (load_s) s_data <= dec;
      end
   end

   assign sa     = m_data.sa;
   assign sb     = m_data.sb;
   assign s_prod = m_data.s_prod;
   assign ea     = m_data.ea;
   assign eb     = m_data.eb;
   assign ma     = m_data.ma;
   assign mb     = m_data.mb;
   assign exc    = m_data.exc;

endmodule

// File: doc/fp_prep_pipe.md
Name: fp_prep_pipe

Overview:
- Parametrised, pipelined operand-preparation stage for the FP multiplier datapath.
- Unpacks two IEEE-754-style operands of configurable exponent/fraction width into sign, biased exponent, mantissa with hidden bit, and input exception flags.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so downstream DSP48E1 stages can stall without losing operands.
- Sits between the operand source and the mantissa-multiply stage.

Parameters:
- EW, 8, exponent field width.
- FW, 23, fraction field width; operand width W = 1+EW+FW.
- DENORM_MODE, 0, 0 = flush subnormals to zero; 1 = keep subnormals (hidden bit 0, effective exponent 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  prepared result valid.
- out_ready  in  1  downstream accepts the result.
- sa, sb  out  1  operand signs.
- s_prod  out  1  sa XOR sb.
- ea, eb  out  EW  biased exponents after subnormal handling.
- ma, mb  out  FW+1  mantissas {hidden, fraction}.
- exc  out  7  exception flags (see below).

Behaviour:
- Per-operand decode:
  - zero: exp==0 and (frac==0 or DENORM_MODE==0).
  - inf: exp all-ones, frac==0.
  - nan: exp all-ones, frac!=0.
  - normal: m={1,frac}, e=exp.
  - zero (including flushed subnormal): m=0, e=0.
  - kept subnormal: m={0,frac}, e=1.
  - inf/nan: e=exp, m={1,frac}.
- exc[6] = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf).
- exc[5:0] = {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero}.
- Transfer rules: accept when in_valid & in_ready; emit when out_valid & out_ready.
- Storage: main output register M plus skid register S. Decode is combinational and is captured on accept; outputs always drive from M.
- States (by occupancy):
  - EMPTY: M invalid. Accept → M, go ONE.
  - ONE: M valid, S invalid.
    - accept & emit → new data into M, stay ONE.
    - emit only → EMPTY.
    - accept only → data into S, go FULL.
  - FULL: M and S valid.
    - emit → S moves to M, go ONE.
    - No accept is possible in FULL.
- in_ready = registered, = (state != FULL). It is never combinationally dependent on out_ready.
- out_valid = (state != EMPTY).
- Latency: 1 cycle from accept to out_valid when unobstructed. Throughput is 1 pair/cycle while out_ready is held high.
- Ordering: strict FIFO; no drops, no duplicates.
- Output data is held stable while out_valid & !out_ready.
- Reset:
  - state=EMPTY, out_valid=0, in_ready=1.
  - All data outputs (sa, sb, s_prod, ea, eb, ma, mb, exc) = 0.
  - Reset mid-operation discards M and S contents. rst has priority over all transfers in the same cycle.
- in_valid while in_ready=0 is ignored. The source must hold its data; the block does not sample it.
- Data outputs while out_valid=0 hold their last value. Zero holds only after reset.

Test Plan:
- Basic decode, EW=8, FW=23, out_ready=1.
  - Stimulus: a=0x40200000, b=0x40980000.
  - Required one cycle later: sa=0, sb=0, ea=0x80, eb=0x81, ma=0xA00000, mb=0x980000, exc=0, s_prod=0.
  - Then a=0x3F800000, b=0xBF800000 → ea=eb=0x7F, ma=mb=0x800000, sb=1, s_prod=1.
- Exceptions.
  - a=0x7F800000, b=0x00000000 → exc=0x49.
  - a=0x7FC00000, b=0x3F800000 → exc=0x60.
  - a=0xFF800000, b=0x40000000 → exc=0x08, sa=1.
- Subnormal handling, a=0x00400000.
  - DENORM_MODE=0 → ea=0, ma=0, exc[1]=1.
  - DENORM_MODE=1 → ea=1, ma=0x400000, exc[1]=0.
- Backpressure.
  - Stimulus: hold out_ready=0; offer pairs P0, P1, P2 back-to-back.
  - Required: P0 and P1 accepted; in_ready=0 from the cycle after the P1 accept; P2 is held at the input.
  - Outputs stay stable at P0 while stalled.
  - Release out_ready → P0, P1, P2 emerge in order on consecutive cycles, with no gaps once streaming.
- Reset mid-operation.
  - Stimulus: FULL state, then assert rst for 1 cycle.
  - Required next cycle: out_valid=0, in_ready=1, all data outputs 0.
  - A new pair then gives out_valid one cycle after accept.
- Half-precision build, EW=5, FW=10.
  - a=0x3C00, b=0x4500 → ea=0x0F, ma=0x400, eb=0x11, mb=0x500, exc=0.
